cordic_vectoring_engine: RTL and testbench

CORDIC_VECTORING_ENGINE -- requirements
Module: cordic_vectoring_engine

---
 rtl/cordic_pkg.sv | 36 +++
 rtl/cordic_vec_stage.sv | 33 +++
 rtl/cordic_vectoring_engine.sv | 156 +++++++++++++++
 tb/tb_cordic_vectoring_engine.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants, ATAN table and FSM state type for the CORDIC vectoring engine.
// All angles and gains are Q3.14 / Q0.14 fixed point.
package cordic_pkg;

  localparam int HALF_PI   = 25736;
  localparam int PI        = 51472;
  localparam int INV_GAIN  = 9949;
  localparam int GAIN_FRAC = 14;

  typedef enum logic [1:0] {StIdle, StIter, StScale, StDone} state_e;

  // atan(2^-i) in Q3.14
  function automatic logic [15:0] atan_lut(input logic [3:0] idx);
    logic [15:0] val;
    case (idx)
      4'd0:    val = 16'd12868;
      4'd1:    val = 16'd7596;
      4'd2:    val = 16'd4014;
      4'd3:    val = 16'd2037;
      4'd4:    val = 16'd1023;
      4'd5:    val = 16'd512;
      4'd6:    val = 16'd256;
      4'd7:    val = 16'd128;
      4'd8:    val = 16'd64;
      4'd9:    val = 16'd32;
      4'd10:   val = 16'd16;
      4'd11:   val = 16'd8;
      4'd12:   val = 16'd4;
      4'd13:   val = 16'd2;
      4'd14:   val = 16'd1;
      default: val = 16'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One vectoring-mode CORDIC micro-rotation; drives y toward zero.
// Purely combinational; both updates use the incoming x and y.
module cordic_vec_stage #(
  parameter int WIDTH = 20
) (
  input  logic signed [WIDTH-1:0] x_i,
  input  logic signed [WIDTH-1:0] y_i,
  input  logic signed [WIDTH-1:0] z_i,
  input  logic        [3:0]       shift_i,
  input  logic signed [WIDTH-1:0] atan_i,
  output logic signed [WIDTH-1:0] x_o,
  output logic signed [WIDTH-1:0] y_o,
  output logic signed [WIDTH-1:0] z_o
);

  logic signed [WIDTH-1:0] x_sh;
  logic signed [WIDTH-1:0] y_sh;

  always_comb begin
    x_sh = x_i >>> shift_i;
    y_sh = y_i >>> shift_i;
    if (!y_i[WIDTH-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + atan_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - atan_i;
    end
  end

endmodule

// File: rtl/cordic_vectoring_engine.sv
// Iterative CORDIC vectoring engine: (x, y) -> (magnitude, atan2(y, x)), Q3.14.
// One micro-rotation per cycle through a single shared stage, then a gain-compensation cycle.
module cordic_vectoring_engine
  import cordic_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int N_ITER     = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic signed [DATA_WIDTH-1:0] in_x,
  input  logic signed [DATA_WIDTH-1:0] in_y,
  input  logic                         i_valid_in,
  output logic                         o_ready_out,
  output logic signed [DATA_WIDTH-1:0] out_magnitude,
  output logic signed [DATA_WIDTH-1:0] out_phase,
  output logic                         o_valid_out,
  input  logic                         i_ready_in
);

  localparam int XW = DATA_WIDTH + 2;
  localparam int PW = XW + 16;
  localparam logic signed [PW-1:0] MagMax   = PW'((1 << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] PhaseMax = XW'(PI);
  localparam logic signed [XW-1:0] PhaseMin = -XW'(PI);

  state_e state_q, state_d;

  logic signed [XW-1:0]         x_q, y_q, z_q, x_d, y_d, z_d;
  logic signed [XW-1:0]         x_ext, y_ext, x_rot, y_rot, z_rot, atan_val;
  logic        [3:0]            iter_q, iter_d;
  logic signed [DATA_WIDTH-1:0] mag_q, mag_d, phase_q, phase_d;
  logic signed [PW-1:0]         prod, scaled;
  logic                         accept;

  assign x_ext    = XW'(in_x);
  assign y_ext    = XW'(in_y);
  assign atan_val = XW'(atan_lut(iter_q));
  assign accept   = i_valid_in && o_ready_out;

  cordic_vec_stage #(
    .WIDTH (XW)
  ) u_stage (
    .x_i     (x_q),
    .y_i     (y_q),
    .z_i     (z_q),
    .shift_i (iter_q),
    .atan_i  (atan_val),
    .x_o     (x_rot),
    .y_o     (y_rot),
    .z_o     (z_rot)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StIter;
      StIter:  if (iter_q == 4'(N_ITER - 1)) state_d = StScale;
      StScale: state_d = StDone;
      StDone:  if (i_ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_ready_out   = (state_q == StIdle) && !i_rst;
    o_valid_out   = (state_q == StDone);
    out_magnitude = mag_q;
    out_phase     = phase_q;
  end

  always_comb begin
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    iter_d  = iter_q;
    mag_d   = mag_q;
    phase_d = phase_q;
    prod    = $signed({{(PW - XW){x_q[XW-1]}}, x_q}) * $signed(PW'(INV_GAIN));
    scaled  = prod >>> GAIN_FRAC;
    case (state_q)
      StIdle: begin
        if (accept) begin
          iter_d = '0;
          // Fold the left half-plane into x >= 0 so the rotations converge.
          if (!in_x[DATA_WIDTH-1]) begin
            x_d = x_ext;
            y_d = y_ext;
            z_d = '0;
          end else if (!in_y[DATA_WIDTH-1]) begin
            x_d = y_ext;
            y_d = -x_ext;
            z_d = XW'(HALF_PI);
          end else begin
            x_d = -y_ext;
            y_d = x_ext;
            z_d = -XW'(HALF_PI);
          end
        end
      end
      StIter: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        iter_d = iter_q + 4'd1;
      end
      StScale: begin
        if (scaled[PW-1]) begin
          mag_d = '0;
        end else if (scaled > MagMax) begin
          mag_d = MagMax[DATA_WIDTH-1:0];
        end else begin
          mag_d = scaled[DATA_WIDTH-1:0];
        end
        // x stays zero only for a zero vector, where z holds the full ATAN sum.
        if (x_q == '0) begin
          phase_d = '0;
        end else if (z_q > PhaseMax) begin
          phase_d = PhaseMax[DATA_WIDTH-1:0];
        end else if (z_q < PhaseMin) begin
          phase_d = PhaseMin[DATA_WIDTH-1:0];
        end else begin
          phase_d = z_q[DATA_WIDTH-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      iter_q  <= '0;
      mag_q   <= '0;
      phase_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      iter_q  <= iter_d;
      mag_q   <= mag_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_engine.sv
// Directed and randomised checks of the CORDIC vectoring engine against hand values
// and a real-valued atan2/hypot model.
module tb_cordic_vectoring_engine;

  localparam int DW  = 18;
  localparam int TOL = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] in_x = '0;
  logic signed [DW-1:0] in_y = '0;
  logic                 valid_in = 1'b0;
  logic                 ready_out;
  logic signed [DW-1:0] mag;
  logic signed [DW-1:0] phase;
  logic                 valid_out;
  logic                 ready_in = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
  } samp_t;

  always #5 clk = ~clk;

  cordic_vectoring_engine #(
    .DATA_WIDTH (DW),
    .N_ITER     (15)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .in_x          (in_x),
    .in_y          (in_y),
    .i_valid_in    (valid_in),
    .o_ready_out   (ready_out),
    .out_magnitude (mag),
    .out_phase     (phase),
    .o_valid_out   (valid_out),
    .i_ready_in    (ready_in)
  );

  // Drives one sample until it is accepted; returns just after the accepting edge.
  task automatic accept_sample(input int x, input int y);
    int n = 0;
    @(negedge clk);
    in_x     = 18'(x);
    in_y     = 18'(y);
    valid_in = 1'b1;
    while (!ready_out && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 50) begin
      n_fail++;
      $display("FAIL accept_timeout: waited %0d cycles, required < 50", n);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!valid_out && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks += 4;
    if (ready_out !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b required 0", ready_out); end
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b required 0", valid_out); end
    if (mag !== '0) begin n_fail++; $display("FAIL rst_mag: got %0d required 0", mag); end
    if (phase !== '0) begin n_fail++; $display("FAIL rst_phase: got %0d required 0", phase); end
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b required 1", ready_out); end
  endtask

  task automatic test_vectors();
    int vx [8] = '{16384, 0,     16384, -16384, -16384, 0, -131072, -131072};
    int vy [8] = '{0,     16384, 16384, 0,      -16384, 0, -131072, 0};
    int em [8] = '{16384, 16384, 23170, 16384,  23170,  0, 131071,  131071};
    int ep [8] = '{0,     25736, 12868, 51472,  -38604, 0, -38604,  51472};
    int lat;
    int d;
    ready_in = 1'b1;
    for (int k = 0; k < 8; k++) begin
      accept_sample(vx[k], vy[k]);
      wait_valid(lat);
      n_checks += 3;
      if (lat != 16) begin n_fail++; $display("FAIL vec%0d_latency: got %0d required 16", k, lat); end
      d = int'(mag) - em[k];
      if (d > TOL || d < -TOL) begin
        n_fail++;
        $display("FAIL vec%0d_mag: got %0d required %0d +/-%0d", k, mag, em[k], TOL);
      end
      d = int'(phase) - ep[k];
      if (d > TOL || d < -TOL) begin
        n_fail++;
        $display("FAIL vec%0d_phase: got %0d required %0d +/-%0d", k, phase, ep[k], TOL);
      end
      @(posedge clk);
      #1;
      n_checks += 2;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL vec%0d_valid_drop: got %b required 0", k, valid_out); end
      if (ready_out !== 1'b1) begin n_fail++; $display("FAIL vec%0d_ready_back: got %b required 1", k, ready_out); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int d;
    logic signed [DW-1:0] hold_mag;
    logic signed [DW-1:0] hold_phase;
    ready_in = 1'b0;
    accept_sample(16384, 16384);
    wait_valid(lat);
    hold_mag   = mag;
    hold_phase = phase;
    n_checks += 3;
    if (lat != 16) begin n_fail++; $display("FAIL bp_latency: got %0d required 16", lat); end
    d = int'(hold_mag) - 23170;
    if (d > TOL || d < -TOL) begin n_fail++; $display("FAIL bp_mag: got %0d required 23170", hold_mag); end
    d = int'(hold_phase) - 12868;
    if (d > TOL || d < -TOL) begin n_fail++; $display("FAIL bp_phase: got %0d required 12868", hold_phase); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      valid_in = k[0];
      in_x     = 18'(-1000 * k);
      in_y     = 18'(777 * k);
      @(posedge clk);
      #1;
      n_checks += 4;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid%0d: got %b required 1", k, valid_out); end
      if (ready_out !== 1'b0) begin n_fail++; $display("FAIL bp_hold_ready%0d: got %b required 0", k, ready_out); end
      if (mag !== hold_mag) begin n_fail++; $display("FAIL bp_hold_mag%0d: got %0d required %0d", k, mag, hold_mag); end
      if (phase !== hold_phase) begin
        n_fail++;
        $display("FAIL bp_hold_phase%0d: got %0d required %0d", k, phase, hold_phase);
      end
    end
    @(negedge clk);
    valid_in = 1'b0;
    ready_in = 1'b1;
    @(posedge clk);
    #1;
    n_checks += 2;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b required 0", valid_out); end
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", ready_out); end
    @(posedge clk);
    #1;
    n_checks++;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_single_handshake: got %b required 0", valid_out); end
  endtask

  task automatic test_mid_reset();
    int lat;
    int d;
    int pulses = 0;
    ready_in = 1'b1;
    accept_sample(16384, 0);
    repeat (7) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (valid_out !== 1'b0) begin n_fail++; $display("FAIL mr_valid: got %b required 0", valid_out); end
    if (ready_out !== 1'b0) begin n_fail++; $display("FAIL mr_ready: got %b required 0", ready_out); end
    if (mag !== '0) begin n_fail++; $display("FAIL mr_mag: got %0d required 0", mag); end
    if (phase !== '0) begin n_fail++; $display("FAIL mr_phase: got %0d required 0", phase); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (ready_out !== 1'b1) begin n_fail++; $display("FAIL mr_release_ready: got %b required 1", ready_out); end
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      if (valid_out) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin n_fail++; $display("FAIL mr_no_valid: got %0d valid cycles required 0", pulses); end
    accept_sample(0, 16384);
    wait_valid(lat);
    n_checks += 3;
    if (lat != 16) begin n_fail++; $display("FAIL mr_next_latency: got %0d required 16", lat); end
    d = int'(mag) - 16384;
    if (d > TOL || d < -TOL) begin n_fail++; $display("FAIL mr_next_mag: got %0d required 16384", mag); end
    d = int'(phase) - 25736;
    if (d > TOL || d < -TOL) begin n_fail++; $display("FAIL mr_next_phase: got %0d required 25736", phase); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    samp_t q[$];
    samp_t s;
    int acc = 0;
    int got = 0;
    int cyc = 0;
    real em;
    real ep;
    while ((acc < 1000 || q.size() > 0) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      ready_in = ($urandom_range(3) != 0);
      if (acc < 1000) begin
        valid_in = ($urandom_range(3) != 0);
        in_x     = 18'($urandom);
        in_y     = 18'($urandom);
      end else begin
        valid_in = 1'b0;
      end
      if (valid_in && ready_out) begin
        s.x = int'(in_x);
        s.y = int'(in_y);
        q.push_back(s);
        acc++;
      end
      if (valid_out && ready_in) begin
        got++;
        n_checks++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rnd_extra_result: got result %0d with no pending sample", got);
        end else begin
          s  = q.pop_front();
          em = $sqrt(real'(s.x) * real'(s.x) + real'(s.y) * real'(s.y));
          if (em > 131071.0) em = 131071.0;
          ep = $atan2(real'(s.y), real'(s.x)) * 16384.0;
          n_checks++;
          if (real'(mag) - em > 8.0 || em - real'(mag) > 8.0) begin
            n_fail++;
            $display("FAIL rnd_mag (%0d,%0d): got %0d required %f +/-8", s.x, s.y, mag, em);
          end
          if (real'(phase) - ep > 8.0 || ep - real'(phase) > 8.0) begin
            n_fail++;
            $display("FAIL rnd_phase (%0d,%0d): got %0d required %f +/-8", s.x, s.y, phase, ep);
          end
        end
      end
    end
    valid_in = 1'b0;
    ready_in = 1'b1;
    n_checks += 2;
    if (got != 1000) begin n_fail++; $display("FAIL rnd_result_count: got %0d required 1000", got); end
    if (q.size() != 0) begin n_fail++; $display("FAIL rnd_pending: got %0d required 0", q.size()); end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
